// File: rtl/prog1_seq_ctrl.sv
// Message fetch / Hamming-encode / store sequencer driving an external encoder and byte-wide data memory.
// Build option PROG1_READBACK_CHECK_EN adds per-message re-read verification and the err_cnt mismatch counter.
module prog1_seq_ctrl #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  dm_addr,
  output logic        dm_wr_en,
  output logic [7:0]  dm_wdata,
  input  logic [7:0]  dm_rdata,
  output logic [10:0] enc_data,
  input  logic [15:0] enc_code,
  output logic [3:0]  msg_idx,
  output logic [3:0]  err_cnt
);
  // state  | meaning
  // IDLE   | waiting for start        RD_LO/RD_HI/CAP | fetch low/high message bytes
  // ENC    | latch encoder codeword   WR_HI/WR_LO     | store codeword bytes
  // VRD_*  | re-read stored bytes     VCMP            | compare readback with codeword
  // NEXT   | advance or finish        DONE            | run complete, waits for start
  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI, CAP, ENC, WR_HI, WR_LO,
`ifdef PROG1_READBACK_CHECK_EN
    VRD_HI, VRD_LO, VCMP,
`endif
    NEXT, DONE
  } state_t;

  localparam logic [7:0] SRC_B    = 8'(SRC_BASE);
  localparam logic [7:0] DST_B    = 8'(DST_BASE);
  localparam logic [3:0] LAST_IDX = 4'(NUM_MSG - 1);

  state_t      state_q, state_d;
  logic [3:0]  msg_idx_q, msg_idx_d;
  logic [10:0] enc_data_q, enc_data_d;
  logic [15:0] codeword_q, codeword_d;
  logic [7:0]  src_lo, dst_lo;
`ifdef PROG1_READBACK_CHECK_EN
  logic [3:0]  err_cnt_q, err_cnt_d;
  logic [7:0]  rb_hi_q, rb_hi_d;
`endif

  assign src_lo = SRC_B + {3'b000, msg_idx_q, 1'b0};
  assign dst_lo = DST_B + {3'b000, msg_idx_q, 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      msg_idx_q  <= '0;
      enc_data_q <= '0;
      codeword_q <= '0;
`ifdef PROG1_READBACK_CHECK_EN
      err_cnt_q  <= '0;
      rb_hi_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      msg_idx_q  <= msg_idx_d;
      enc_data_q <= enc_data_d;
      codeword_q <= codeword_d;
`ifdef PROG1_READBACK_CHECK_EN
      err_cnt_q  <= err_cnt_d;
      rb_hi_q    <= rb_hi_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    msg_idx_d  = msg_idx_q;
    enc_data_d = enc_data_q;
    codeword_d = codeword_q;
    dm_addr    = 8'd0;
    dm_wr_en   = 1'b0;
    dm_wdata   = 8'd0;
`ifdef PROG1_READBACK_CHECK_EN
    err_cnt_d  = err_cnt_q;
    rb_hi_d    = rb_hi_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RD_LO;
          msg_idx_d = '0;
`ifdef PROG1_READBACK_CHECK_EN
          err_cnt_d = '0;
`endif
        end
      end
      RD_LO: begin
        dm_addr = src_lo;
        state_d = RD_HI;
      end
      RD_HI: begin
        dm_addr          = src_lo + 8'd1;
        enc_data_d[7:0]  = dm_rdata;
        state_d          = CAP;
      end
      // Only three message bits live in the high source byte.
      CAP: begin
        dm_addr          = src_lo + 8'd1;
        enc_data_d[10:8] = dm_rdata[2:0];
        state_d          = ENC;
      end
      ENC: begin
        dm_addr    = src_lo + 8'd1;
        codeword_d = enc_code;
        state_d    = WR_HI;
      end
      WR_HI: begin
        dm_addr  = dst_lo + 8'd1;
        dm_wr_en = 1'b1;
        dm_wdata = codeword_q[15:8];
        state_d  = WR_LO;
      end
      WR_LO: begin
        dm_addr  = dst_lo;
        dm_wr_en = 1'b1;
        dm_wdata = codeword_q[7:0];
`ifdef PROG1_READBACK_CHECK_EN
        state_d  = VRD_HI;
`else
        state_d  = NEXT;
`endif
      end
`ifdef PROG1_READBACK_CHECK_EN
      VRD_HI: begin
        dm_addr = dst_lo + 8'd1;
        state_d = VRD_LO;
      end
      VRD_LO: begin
        dm_addr = dst_lo;
        rb_hi_d = dm_rdata;
        state_d = VCMP;
      end
      VCMP: begin
        dm_addr = dst_lo;
        if (({rb_hi_q, dm_rdata} != codeword_q) && (err_cnt_q != 4'hF))
          err_cnt_d = err_cnt_q + 4'd1;
        state_d = NEXT;
      end
`endif
      NEXT: begin
        dm_addr = dst_lo;
        if (msg_idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          msg_idx_d = msg_idx_q + 4'd1;
          state_d   = RD_LO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
  assign enc_data = enc_data_q;
  assign msg_idx  = msg_idx_q;
`ifdef PROG1_READBACK_CHECK_EN
  assign err_cnt  = err_cnt_q;
`else
  assign err_cnt  = 4'd0;
`endif

endmodule

// File: tb/tb_prog1_seq_ctrl.sv
// Directed bench: dut_a (NUM_MSG=1, pass-through encoder) and dut_b (default, SECDED encoder),
// each with its own byte memory; cycle counts adapt to PROG1_READBACK_CHECK_EN.
module tb_prog1_seq_ctrl;
`ifdef PROG1_READBACK_CHECK_EN
  localparam int LAT     = 10;
  localparam int ERR_EXP = 1;
`else
  localparam int LAT     = 7;
  localparam int ERR_EXP = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_a, start_a, busy_a, done_a, wr_a;
  logic [7:0]  addr_a, wdata_a, rdata_a;
  logic [10:0] enc_a;
  logic [15:0] code_a;
  logic [3:0]  idx_a, err_a;

  logic        rst_b, start_b, busy_b, done_b, wr_b;
  logic [7:0]  addr_b, wdata_b, rdata_b;
  logic [10:0] enc_b;
  logic [15:0] code_b;
  logic [3:0]  idx_b, err_b;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic       ld_en = 1'b0, ld_sel = 1'b0, corrupt = 1'b0;
  logic [7:0] ld_addr = 8'd0, ld_data = 8'd0;
  logic [7:0] src_tbl [30];

  function automatic logic [15:0] secded(input logic [10:0] d);
    logic [15:0] c;
    int          k;
    logic        par;
    c = '0;
    k = 0;
    for (int p = 1; p < 16; p++)
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    for (int b = 0; b < 4; b++) begin
      par = 1'b0;
      for (int p = 1; p < 16; p++)
        if (((p >> b) & 1) == 1) par ^= c[p-1];
      c[(1 << b) - 1] = par;
    end
    c[15] = ^c[14:0];
    return c;
  endfunction

  assign code_a = {5'b00000, enc_a};
  assign code_b = secded(enc_b);

  prog1_seq_ctrl #(.NUM_MSG(1)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .dm_addr(addr_a), .dm_wr_en(wr_a), .dm_wdata(wdata_a), .dm_rdata(rdata_a),
    .enc_data(enc_a), .enc_code(code_a), .msg_idx(idx_a), .err_cnt(err_a)
  );

  prog1_seq_ctrl dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .dm_addr(addr_b), .dm_wr_en(wr_b), .dm_wdata(wdata_b), .dm_rdata(rdata_b),
    .enc_data(enc_b), .enc_code(code_b), .msg_idx(idx_b), .err_cnt(err_b)
  );

  always @(posedge clk) begin
    if (ld_en && !ld_sel) mem_a[ld_addr] <= ld_data;
    else if (wr_a)        mem_a[addr_a]  <= wdata_a;
    rdata_a <= mem_a[addr_a];
  end

  always @(posedge clk) begin
    if (ld_en && ld_sel) mem_b[ld_addr] <= ld_data;
    else if (wr_b)       mem_b[addr_b]  <= wdata_b ^ ((corrupt && addr_b == 8'd33) ? 8'hFF : 8'h00);
    rdata_b <= mem_b[addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input logic [7:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic run_a(output int cyc);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 1;
    while (!done_a && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_b(input int pulse_at, output int cyc);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("start_done_low", 32'(done_b), 32'd0);
    chk("start_busy", 32'(busy_b), 32'd1);
    chk("start_idx_zero", 32'(idx_b), 32'd0);
    chk("start_err_clear", 32'(err_b), 32'd0);
    cyc = 1;
    while (!done_b && cyc < 400) begin
      start_b = (cyc == pulse_at);
      tick();
      cyc++;
    end
    start_b = 1'b0;
  endtask

  initial begin
    int          cyc;
    int          bad;
    logic [15:0] cw;

    src_tbl = '{8'h5A, 8'h07, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h12, 8'h04, 8'h81, 8'hF2,
                8'h3C, 8'h01, 8'hC3, 8'h06, 8'h99, 8'h05, 8'h66, 8'h02, 8'hE7, 8'hF8,
                8'h01, 8'h00, 8'h80, 8'h07, 8'h7F, 8'h03, 8'hAA, 8'h05, 8'h55, 8'hFA};
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_b), 32'd0);
    chk("rst_done", 32'(done_b), 32'd0);
    chk("rst_wr_en", 32'(wr_b), 32'd0);
    chk("rst_addr", 32'(addr_b), 32'd0);
    chk("rst_wdata", 32'(wdata_b), 32'd0);
    chk("rst_enc_data", 32'(enc_b), 32'd0);
    chk("rst_idx", 32'(idx_b), 32'd0);
    chk("rst_err", 32'(err_b), 32'd0);
    chk("rst_a_busy_done", 32'({busy_a, done_a, wr_a}), 32'd0);
    tick();
    tick();
    rst_a = 1'b1; rst_b = 1'b1;
    tick();
    chk("idle_no_start", 32'(busy_b), 32'd0);

    start_b = 1'b1;
    #3;
    start_b = 1'b0;
    tick();
    chk("short_pulse_busy", 32'(busy_b), 32'd0);
    chk("short_pulse_done", 32'(done_b), 32'd0);

    load(1'b0, 8'd0, 8'hA5);
    load(1'b0, 8'd1, 8'h03);
    run_a(cyc);
    chk("a_done_cycle", 32'(cyc), 32'(1 + LAT));
    chk("a_enc_data", 32'(enc_a), 32'h3A5);
    chk("a_mem30", 32'(mem_a[30]), 32'hA5);
    chk("a_mem31", 32'(mem_a[31]), 32'h03);
    chk("a_done_wr_en", 32'(wr_a), 32'd0);
    chk("a_done_addr", 32'(addr_a), 32'd0);
    chk("a_idx_err", 32'({idx_a, err_a}), 32'd0);

    load(1'b0, 8'd1, 8'hFB);
    load(1'b0, 8'd31, 8'h00);
    run_a(cyc);
    chk("a2_done_cycle", 32'(cyc), 32'(1 + LAT));
    chk("a2_enc_upper_ignored", 32'(enc_a), 32'h3A5);
    chk("a2_mem31", 32'(mem_a[31]), 32'h03);

    for (int i = 0; i < 30; i++) load(1'b1, 8'(i), src_tbl[i]);
    run_b(0, cyc);
    chk("b_done_cycle", 32'(cyc), 32'(1 + 15 * LAT));
    for (int i = 0; i < 15; i++) begin
      cw = secded({src_tbl[2*i+1][2:0], src_tbl[2*i]});
      chk("b_code_lo", 32'(mem_b[30 + 2*i]), 32'(cw[7:0]));
      chk("b_code_hi", 32'(mem_b[31 + 2*i]), 32'(cw[15:8]));
    end
    chk("b_enc_hold", 32'(enc_b), 32'h255);
    chk("b_last_idx", 32'(idx_b), 32'd14);
    tick(); tick(); tick();
    chk("b_busy_after", 32'(busy_b), 32'd0);
    chk("b_done_hold", 32'(done_b), 32'd1);
    chk("b_err", 32'(err_b), 32'd0);

    run_b(20, cyc);
    chk("midrun_start_ignored", 32'(cyc), 32'(1 + 15 * LAT));
    run_b(0, cyc);
    chk("restart_from_done", 32'(cyc), 32'(1 + 15 * LAT));

    for (int i = 30; i < 60; i++) load(1'b1, 8'(i), 8'hEE);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 1;
    while (cyc < 1 + 7 * LAT + 4) begin
      tick();
      cyc++;
    end
    chk("m7_wr_hi_en", 32'(wr_b), 32'd1);
    chk("m7_wr_hi_addr", 32'(addr_b), 32'd45);
    chk("m7_idx", 32'(idx_b), 32'd7);
    #2;
    rst_b = 1'b0;
    #1;
    chk("midrst_outputs",
        32'({busy_b, done_b, wr_b, addr_b, wdata_b, idx_b, err_b}), 32'd0);
    chk("midrst_enc", 32'(enc_b), 32'd0);
    tick();
    #2;
    rst_b = 1'b1;
    repeat (5) tick();
    chk("no_resume_busy", 32'(busy_b), 32'd0);
    chk("no_resume_done", 32'(done_b), 32'd0);
    bad = 0;
    for (int i = 44; i < 60; i++) if (mem_b[i] !== 8'hEE) bad++;
    chk("rst_dst_untouched", 32'(bad), 32'd0);
    cw = secded({src_tbl[13][2:0], src_tbl[12]});
    chk("pre_rst_msg6_hi", 32'(mem_b[43]), 32'(cw[15:8]));

    corrupt = 1'b1;
    run_b(0, cyc);
    corrupt = 1'b0;
    chk("corrupt_done_cycle", 32'(cyc), 32'(1 + 15 * LAT));
    chk("corrupt_err_cnt", 32'(err_b), 32'(ERR_EXP));
    cw = secded({src_tbl[3][2:0], src_tbl[2]});
    chk("corrupt_mem33", 32'(mem_b[33]), 32'(cw[15:8] ^ 8'hFF));
    run_b(0, cyc);
    chk("clean_err_cnt", 32'(err_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
